// File: rtl/gcd_engine.sv
// Iterative subtractive GCD engine with valid/ready handshakes on both sides.
// One subtraction per CALC cycle; the result is held in DONE until it is consumed.
module gcd_engine #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd_out,
  output logic [WIDTH-1:0] iter_count,
  output logic             zero_flag
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic [WIDTH-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0] res_r, res_s;
  logic [WIDTH-1:0] iter_r, iter_s;
  logic             zf_r, zf_s;
  logic             in_ready_r, in_ready_s;
  logic             out_valid_r, out_valid_s;

  logic             a_zero_s;
  logic             b_zero_s;
  logic             a_gt_b_s;
  logic             term_s;
  logic [WIDTH-1:0] a_minus_b_s;
  logic [WIDTH-1:0] b_minus_a_s;

  // The larger operand is always the minuend, so neither difference can underflow when used.
  assign a_zero_s    = (a_r == ZERO_W);
  assign b_zero_s    = (b_r == ZERO_W);
  assign a_gt_b_s    = (a_r > b_r);
  assign term_s      = (a_r == b_r) || a_zero_s || b_zero_s;
  assign a_minus_b_s = a_r - b_r;
  assign b_minus_a_s = b_r - a_r;

  // Next-state and next-register values; everything holds unless a transition says otherwise.
  always_comb begin
    state_s     = state_r;
    a_s         = a_r;
    b_s         = b_r;
    cnt_s       = cnt_r;
    res_s       = res_r;
    iter_s      = iter_r;
    zf_s        = zf_r;
    in_ready_s  = in_ready_r;
    out_valid_s = out_valid_r;

    case (state_r)
      IDLE: begin
        if (in_valid) begin
          a_s        = a_in;
          b_s        = b_in;
          cnt_s      = ZERO_W;
          in_ready_s = 1'b0;
          state_s    = CALC;
        end else begin
          state_s    = IDLE;
        end
      end

      CALC: begin
        if (term_s) begin
          res_s       = a_zero_s ? b_r : a_r;
          iter_s      = cnt_r;
          zf_s        = a_zero_s && b_zero_s;
          out_valid_s = 1'b1;
          state_s     = DONE;
        end else if (a_gt_b_s) begin
          a_s   = a_minus_b_s;
          cnt_s = cnt_r + ONE_W;
        end else begin
          b_s   = b_minus_a_s;
          cnt_s = cnt_r + ONE_W;
        end
      end

      DONE: begin
        // Results are zeroed on the way out so they read 0 whenever out_valid is low.
        if (out_ready) begin
          res_s       = ZERO_W;
          iter_s      = ZERO_W;
          zf_s        = 1'b0;
          out_valid_s = 1'b0;
          in_ready_s  = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s     = DONE;
        end
      end

      default: begin
        a_s         = ZERO_W;
        b_s         = ZERO_W;
        cnt_s       = ZERO_W;
        res_s       = ZERO_W;
        iter_s      = ZERO_W;
        zf_s        = 1'b0;
        out_valid_s = 1'b0;
        in_ready_s  = 1'b1;
        state_s     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight computation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      a_r         <= ZERO_W;
      b_r         <= ZERO_W;
      cnt_r       <= ZERO_W;
      res_r       <= ZERO_W;
      iter_r      <= ZERO_W;
      zf_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      a_r         <= a_s;
      b_r         <= b_s;
      cnt_r       <= cnt_s;
      res_r       <= res_s;
      iter_r      <= iter_s;
      zf_r        <= zf_s;
      in_ready_r  <= in_ready_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign gcd_out    = res_r;
  assign iter_count = iter_r;
  assign zero_flag  = zf_r;

endmodule

// File: tb/tb_gcd_engine.sv
// Scoreboard-driven bench for gcd_engine: 16-bit instance for most scenarios,
// 8-bit instance for the worst-case iteration count.
module tb_gcd_engine;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready, zero_flag;
  logic [W-1:0] a_in, b_in, gcd_out, iter_count;
  logic         in_valid8, in_ready8, out_valid8, out_ready8, zero_flag8;
  logic [7:0]   a_in8, b_in8, gcd_out8, iter_count8;

  typedef struct {
    logic [W-1:0] g;
    logic [W-1:0] it;
    logic         zf;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  gcd_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
    .gcd_out(gcd_out), .iter_count(iter_count), .zero_flag(zero_flag)
  );

  gcd_engine #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .a_in(a_in8), .b_in(b_in8), .out_valid(out_valid8), .out_ready(out_ready8),
    .gcd_out(gcd_out8), .iter_count(iter_count8), .zero_flag(zero_flag8)
  );

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    int           n;
    x = a; y = b; n = 0;
    while (!(x == y || x == 16'd0 || y == 16'd0)) begin
      if (x > y) x = x - y;
      else       y = y - x;
      n++;
    end
    e.g   = (x == 16'd0) ? y : x;
    e.it  = 16'(n);
    e.zf  = (x == 16'd0) && (y == 16'd0);
    e.lat = n + 1;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] g, input logic [W-1:0] it, input logic zf, input int lat);
    exp_t e;
    e.g = g; e.it = it; e.zf = zf; e.lat = lat;
    return e;
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1; a_in = a; b_in = b;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts edges after the accepting edge until out_valid is seen at a falling edge.
  task automatic collect(input int budget, output logic [W-1:0] g, output logic [W-1:0] it,
                         output logic zf, output int lat, output bit seen);
    lat = 0; seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid === 1'b1) seen = 1'b1;
    end
    g = gcd_out; it = iter_count; zf = zero_flag;
  endtask

  task automatic test_reset;
    logic [W-1:0] g, it; logic zf; int lat; bit seen; exp_t e;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = 16'd0; b_in = 16'd0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a_in8 = 8'd0; b_in8 = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || gcd_out !== 16'd0 || iter_count !== 16'd0 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset16: rdy=%b vld=%b g=%0d it=%0d zf=%b, want 1 0 0 0 0", in_ready, out_valid, gcd_out, iter_count, zero_flag);
    end
    checks++;
    if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0 || gcd_out8 !== 8'd0 || iter_count8 !== 8'd0 || zero_flag8 !== 1'b0) begin
      errors++;
      $display("FAIL reset8: rdy=%b vld=%b g=%0d it=%0d zf=%b, want 1 0 0 0 0", in_ready8, out_valid8, gcd_out8, iter_count8, zero_flag8);
    end
    // A pair offered while reset is held must wait for the first edge with rst low.
    in_valid = 1'b1; a_in = 16'd21; b_in = 16'd14;
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_in_reset: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    rst = 1'b0;
    sb.push_back(mk(16'd7, 16'd2, 1'b0, 3));
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect(20, g, it, zf, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e.g || it !== e.it || zf !== e.zf || lat != e.lat) begin
      errors++;
      $display("FAIL first_accept: seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
               seen, g, it, zf, lat, e.g, e.it, e.zf, e.lat);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_basic;
    logic [W-1:0] g, it; logic zf; int lat; bit seen; exp_t e;
    out_ready = 1'b1;
    sb.push_back(mk(16'd6, 16'd4, 1'b0, 5));
    accept(16'd48, 16'd18);
    collect(50, g, it, zf, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e.g || it !== e.it || zf !== e.zf || lat != e.lat) begin
      errors++;
      $display("FAIL basic_48_18: seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
               seen, g, it, zf, lat, e.g, e.it, e.zf, e.lat);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL done_in_ready: got %b want 0", in_ready);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || gcd_out !== 16'd0 || iter_count !== 16'd0 || zero_flag !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: vld=%b rdy=%b g=%0d it=%0d zf=%b, want 0 1 0 0 0", out_valid, in_ready, gcd_out, iter_count, zero_flag);
    end
  endtask

  task automatic test_hold;
    logic [W-1:0] g, it; logic zf; int lat; bit seen; exp_t e;
    out_ready = 1'b0;
    sb.push_back(mk(16'd6, 16'd2, 1'b0, 3));
    accept(16'd12, 16'd18);
    collect(50, g, it, zf, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e.g || it !== e.it || zf !== e.zf || lat != e.lat) begin
      errors++;
      $display("FAIL hold_12_18: seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
               seen, g, it, zf, lat, e.g, e.it, e.zf, e.lat);
    end
    // New pair offered during DONE must be ignored while the result is held.
    in_valid = 1'b1; a_in = 16'd100; b_in = 16'd75;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || gcd_out !== e.g || iter_count !== e.it || zero_flag !== e.zf) begin
        errors++;
        $display("FAIL hold_stable[%0d]: vld=%b rdy=%b g=%0d it=%0d zf=%b, want 1 0 %0d %0d %b",
                 c, out_valid, in_ready, gcd_out, iter_count, zero_flag, e.g, e.it, e.zf);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || gcd_out !== 16'd0) begin
      errors++;
      $display("FAIL hold_release: vld=%b rdy=%b g=%0d, want 0 1 0", out_valid, in_ready, gcd_out);
    end
  endtask

  task automatic test_edges;
    logic [W-1:0] a_t [4] = '{16'd0, 16'd9, 16'd0, 16'd5};
    logic [W-1:0] b_t [4] = '{16'd7, 16'd0, 16'd0, 16'd5};
    logic [W-1:0] g_t [4] = '{16'd7, 16'd9, 16'd0, 16'd5};
    logic         z_t [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W-1:0] g, it; logic zf; int lat; bit seen; exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(g_t[i], 16'd0, z_t[i], 1));
      accept(a_t[i], b_t[i]);
      collect(10, g, it, zf, lat, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || g !== e.g || it !== e.it || zf !== e.zf || lat != e.lat) begin
        errors++;
        $display("FAIL edge(%0d,%0d): seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
                 a_t[i], b_t[i], seen, g, it, zf, lat, e.g, e.it, e.zf, e.lat);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if (zero_flag !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL edge_clear: zf=%b vld=%b, want 0 0", zero_flag, out_valid);
      end
    end
  endtask

  task automatic test_width8;
    int lat; bit seen; exp_t e;
    out_ready8 = 1'b1;
    sb.push_back(mk(16'd1, 16'd254, 1'b0, 255));
    @(negedge clk);
    in_valid8 = 1'b1; a_in8 = 8'd255; b_in8 = 8'd1;
    @(posedge clk);
    #1 in_valid8 = 1'b0;
    lat = 0; seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if (out_valid8 === 1'b1) seen = 1'b1;
    end
    e = sb.pop_front();
    checks++;
    if (!seen || gcd_out8 !== e.g[7:0] || iter_count8 !== e.it[7:0] || zero_flag8 !== e.zf || lat != e.lat) begin
      errors++;
      $display("FAIL w8_255_1: seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
               seen, gcd_out8, iter_count8, zero_flag8, lat, e.g, e.it, e.zf, e.lat);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || iter_count8 !== 8'd0) begin
      errors++;
      $display("FAIL w8_release: vld=%b rdy=%b it=%0d, want 0 1 0", out_valid8, in_ready8, iter_count8);
    end
    out_ready8 = 1'b0;
  endtask

  task automatic test_reset_midcalc;
    logic [W-1:0] g, it; logic zf; int lat; bit seen; bit stray; exp_t e;
    out_ready = 1'b1;
    sb.push_back(mk(16'd6, 16'd4, 1'b0, 5));
    accept(16'd48, 16'd18);
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || gcd_out !== 16'd0 || iter_count !== 16'd0) begin
      errors++;
      $display("FAIL midcalc_async: rdy=%b vld=%b g=%0d it=%0d, want 1 0 0 0", in_ready, out_valid, gcd_out, iter_count);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_next: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    rst = 1'b0;
    stray = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      errors++;
      $display("FAIL midcalc_discard: stray result or busy after reset, got %b want 0", stray);
    end
    sb.push_back(mk(16'd7, 16'd2, 1'b0, 3));
    accept(16'd21, 16'd14);
    collect(20, g, it, zf, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e.g || it !== e.it || zf !== e.zf || lat != e.lat) begin
      errors++;
      $display("FAIL after_reset_21_14: seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
               seen, g, it, zf, lat, e.g, e.it, e.zf, e.lat);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] g, it; logic zf; int lat; bit seen; exp_t e;
    out_ready = 1'b1;
    sb.push_back(mk(16'd6, 16'd4, 1'b0, 5));
    sb.push_back(mk(16'd7, 16'd2, 1'b0, 3));
    @(negedge clk);
    in_valid = 1'b1; a_in = 16'd48; b_in = 16'd18;
    @(posedge clk);
    #1 a_in = 16'd21; b_in = 16'd14;
    collect(50, g, it, zf, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e.g || it !== e.it || zf !== e.zf || lat != e.lat) begin
      errors++;
      $display("FAIL b2b_first: seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
               seen, g, it, zf, lat, e.g, e.it, e.zf, e.lat);
    end
    @(posedge clk); @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_same_cycle: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    collect(50, g, it, zf, lat, seen);
    e = sb.pop_front();
    checks++;
    if (!seen || g !== e.g || it !== e.it || zf !== e.zf || lat != e.lat) begin
      errors++;
      $display("FAIL b2b_second: seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
               seen, g, it, zf, lat, e.g, e.it, e.zf, e.lat);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_random;
    logic [W-1:0] a, b, g, it; logic zf; int lat; bit seen; exp_t e;
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = 16'($urandom_range(1, 200));
      b = 16'($urandom_range(0, 200));
      sb.push_back(model(a, b));
      accept(a, b);
      collect(300, g, it, zf, lat, seen);
      e = sb.pop_front();
      checks++;
      if (!seen || g !== e.g || it !== e.it || zf !== e.zf || lat != e.lat) begin
        errors++;
        $display("FAIL rand(%0d,%0d): seen=%b g=%0d it=%0d zf=%b lat=%0d, want g=%0d it=%0d zf=%b lat=%0d",
                 a, b, seen, g, it, zf, lat, e.g, e.it, e.zf, e.lat);
      end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || gcd_out !== e.g || iter_count !== e.it) begin
        errors++;
        $display("FAIL rand_hold: vld=%b g=%0d it=%0d, want 1 %0d %0d", out_valid, gcd_out, iter_count, e.g, e.it);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_edges();
    test_width8();
    test_reset_midcalc();
    test_back_to_back();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
